// File: rtl/cam_dvp_capture_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_dvp_capture_if : RGB888 pixel stream with coordinates and line markers
// Revision: 1.0
// ----------------------------------------------------------------------------
interface cam_dvp_capture_if #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12
);
  logic              pix_valid;
  logic [23:0]       pix_rgb;
  logic [X_BITS-1:0] pix_x;
  logic [Y_BITS-1:0] pix_y;
  logic              sof;
  logic              eol;

  modport master (output pix_valid, pix_rgb, pix_x, pix_y, sof, eol);
  modport slave  (input  pix_valid, pix_rgb, pix_x, pix_y, sof, eol);
endinterface
`default_nettype wire

// File: rtl/cam_dvp_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_dvp_capture : DVP RGB565 byte capture, RGB888 expansion, geometry checks
// Revision: 1.0
// ----------------------------------------------------------------------------
module cam_dvp_capture #(
  parameter int   X_BITS    = 12,
  parameter int   Y_BITS    = 12,
  parameter int   H_ACTIVE  = 640,
  parameter int   V_ACTIVE  = 480,
  parameter logic VSYNC_POL = 1'b1,
  parameter logic BYTE_SWAP = 1'b0
) (
  input  wire logic         clk_i,
  input  wire logic         reset_i,
  input  wire logic         enable_i,
  input  wire logic         err_clr_i,
  input  wire logic         cam_vsync_i,
  input  wire logic         cam_href_i,
  input  wire logic [7:0]   cam_data_i,
  cam_dvp_capture_if.master pix_o,
  output logic              frame_done_o,
  output logic [15:0]       frame_count_o,
  output logic [2:0]        err_status_o,
  output logic              busy_o
);

  localparam logic [X_BITS-1:0] c_h_act  = X_BITS'(H_ACTIVE);
  localparam logic [X_BITS-1:0] c_h_last = X_BITS'(H_ACTIVE - 1);
  localparam logic [Y_BITS-1:0] c_v_act  = Y_BITS'(V_ACTIVE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SYNC = 2'd1, S_FRAME = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              vsync_q, href_q;
  logic [7:0]        data_q;
  logic              vs_prev_q, line_prev_q;
  logic              phase_q, phase_d;
  logic [7:0]        first_q, first_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d, y_line;

  logic              p_valid_q, p_valid_d;
  logic [15:0]       p_word_q, p_word_d;
  logic [X_BITS-1:0] p_x_q, p_x_d;
  logic [Y_BITS-1:0] p_y_q, p_y_d;
  logic              p_sof_q, p_sof_d, p_eol_q, p_eol_d;

  logic              pix_valid_q, sof_q, eol_q;
  logic [23:0]       pix_rgb_q;
  logic [X_BITS-1:0] pix_x_q;
  logic [Y_BITS-1:0] pix_y_q;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [2:0]        err_q, err_set;
  logic              busy_q;

  logic              vs_act, line_act, vs_rise, vs_fall, line_end;
  logic [15:0]       word;

  // VSYNC overrides HREF, so a line cut short by VSYNC ends like an HREF fall.
  assign vs_act   = (vsync_q == VSYNC_POL);
  assign line_act = href_q & ~vs_act;
  assign vs_rise  = vs_act & ~vs_prev_q;
  assign vs_fall  = ~vs_act & vs_prev_q;
  assign line_end = line_prev_q & ~line_act;
  assign word     = BYTE_SWAP ? {data_q, first_q} : {first_q, data_q};

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    first_d       = first_q;
    x_d           = x_q;
    y_d           = y_q;
    y_line        = y_q;
    p_valid_d     = 1'b0;
    p_word_d      = p_word_q;
    p_x_d         = p_x_q;
    p_y_d         = p_y_q;
    p_sof_d       = 1'b0;
    p_eol_d       = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_set       = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (vs_fall) begin
          state_d = S_FRAME;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
        end
      end
      S_FRAME: begin
        if (line_act) begin
          if (!phase_q) begin
            first_d = data_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((x_q < c_h_act) && (y_q < c_v_act)) begin
              p_valid_d = 1'b1;
              p_word_d  = word;
              p_x_d     = x_q;
              p_y_d     = y_q;
              p_sof_d   = (x_q == '0) && (y_q == '0);
              p_eol_d   = (x_q == c_h_last);
            end
            if (x_q != '1) x_d = x_q + X_BITS'(1);
          end
        end
        if (line_end) begin
          err_set[0] = phase_q;
          err_set[1] = (x_q != c_h_act);
          x_d        = '0;
          phase_d    = 1'b0;
          y_line     = (y_q != c_v_act) ? y_q + Y_BITS'(1) : y_q;
          y_d        = y_line;
        end
        if (vs_rise) begin
          err_set[2]    = (y_line != c_v_act);
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          x_d           = '0;
          y_d           = '0;
          phase_d       = 1'b0;
          state_d       = enable_i ? S_FRAME : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= 8'd0;
      vs_prev_q     <= 1'b0;
      line_prev_q   <= 1'b0;
      phase_q       <= 1'b0;
      first_q       <= 8'd0;
      x_q           <= '0;
      y_q           <= '0;
      p_valid_q     <= 1'b0;
      p_word_q      <= 16'd0;
      p_x_q         <= '0;
      p_y_q         <= '0;
      p_sof_q       <= 1'b0;
      p_eol_q       <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_rgb_q     <= 24'd0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      err_q         <= 3'b000;
      busy_q        <= 1'b0;
    end else begin
      vsync_q       <= cam_vsync_i;
      href_q        <= cam_href_i;
      data_q        <= cam_data_i;
      vs_prev_q     <= vs_act;
      line_prev_q   <= line_act;
      state_q       <= state_d;
      phase_q       <= phase_d;
      first_q       <= first_d;
      x_q           <= x_d;
      y_q           <= y_d;
      p_valid_q     <= p_valid_d;
      p_word_q      <= p_word_d;
      p_x_q         <= p_x_d;
      p_y_q         <= p_y_d;
      p_sof_q       <= p_sof_d;
      p_eol_q       <= p_eol_d;
      pix_valid_q   <= p_valid_q;
      pix_rgb_q     <= {p_word_q[15:11], p_word_q[15:13],
                        p_word_q[10:5],  p_word_q[10:9],
                        p_word_q[4:0],   p_word_q[4:2]};
      pix_x_q       <= p_x_q;
      pix_y_q       <= p_y_q;
      sof_q         <= p_sof_q;
      eol_q         <= p_eol_q;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      // A fresh error in the clearing cycle still lands.
      err_q         <= (err_clr_i ? 3'b000 : err_q) | err_set;
      busy_q        <= (state_d == S_FRAME);
    end
  end

  assign pix_o.pix_valid = pix_valid_q;
  assign pix_o.pix_rgb   = pix_rgb_q;
  assign pix_o.pix_x     = pix_x_q;
  assign pix_o.pix_y     = pix_y_q;
  assign pix_o.sof       = sof_q;
  assign pix_o.eol       = eol_q;
  assign frame_done_o    = frame_done_q;
  assign frame_count_o   = frame_count_q;
  assign err_status_o    = err_q;
  assign busy_o          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_dvp_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cam_dvp_capture : directed table-driven bench, 4x2 frame geometry
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cam_dvp_capture;
  localparam int X_BITS = 12;
  localparam int Y_BITS = 12;
  localparam int H_ACT  = 4;
  localparam int V_ACT  = 2;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [23:0] rgb;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        err_clr = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [2:0]  err_status;
  logic        busy;

  int          n_chk = 0;
  int          n_err = 0;
  int          fd_cnt = 0;
  int          fd0;
  logic [23:0] q_rgb[$];
  int          q_x[$];
  int          q_y[$];
  logic        q_sof[$];
  logic        q_eol[$];
  logic [7:0]  tx_q[$];
  vec_t        vec[8];

  always #5 clk = ~clk;

  cam_dvp_capture_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) pif ();

  cam_dvp_capture #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
    .VSYNC_POL(1'b1), .BYTE_SWAP(1'b0)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .err_clr_i    (err_clr),
    .cam_vsync_i  (vsync),
    .cam_href_i   (href),
    .cam_data_i   (data),
    .pix_o        (pif),
    .frame_done_o (frame_done),
    .frame_count_o(frame_count),
    .err_status_o (err_status),
    .busy_o       (busy)
  );

  always @(negedge clk) begin
    if (pif.pix_valid) begin
      q_rgb.push_back(pif.pix_rgb);
      q_x.push_back(int'(pif.pix_x));
      q_y.push_back(int'(pif.pix_y));
      q_sof.push_back(pif.sof);
      q_eol.push_back(pif.eol);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    q_rgb.delete(); q_x.delete(); q_y.delete(); q_sof.delete(); q_eol.delete();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(3);
  endtask

  task automatic send_line();
    href = 1'b1;
    foreach (tx_q[i]) begin
      data = tx_q[i];
      tick(1);
    end
    href = 1'b0;
    data = 8'd0;
    tick(3);
  endtask

  task automatic fill_line(input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back((i % 2 == 0) ? 8'hF8 : 8'h00);
    send_line();
  endtask

  task automatic send_frame(input int lines, input int nbytes);
    for (int l = 0; l < lines; l++) fill_line(nbytes);
  endtask

  task automatic send_table_frame();
    for (int l = 0; l < V_ACT; l++) begin
      tx_q.delete();
      for (int p = 0; p < H_ACT; p++) begin
        tx_q.push_back(vec[l*H_ACT+p].hi);
        tx_q.push_back(vec[l*H_ACT+p].lo);
      end
      send_line();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec[0] = '{8'hF8, 8'h00, 24'hFF0000};
    vec[1] = '{8'h07, 8'hE0, 24'h00FF00};
    vec[2] = '{8'h00, 8'h1F, 24'h0000FF};
    vec[3] = '{8'hFF, 8'hFF, 24'hFFFFFF};
    vec[4] = '{8'h00, 8'h00, 24'h000000};
    vec[5] = '{8'h84, 8'h10, 24'h848284};
    vec[6] = '{8'h12, 8'h34, 24'h1045A5};
    vec[7] = '{8'hAB, 8'hCD, 24'hAD796B};

    tick(3);
    chk("rst_valid", pif.pix_valid, 1'b0);
    chk("rst_count", frame_count, 16'd0);
    chk("rst_err", err_status, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    reset = 1'b0;
    tick(2);

    // Two clean frames driven from the vector table.
    enable = 1'b1;
    tick(3);
    chk("sync_busy", busy, 1'b0);
    vs_pulse();
    chk("frame_busy", busy, 1'b1);
    clear_q();
    fd0 = fd_cnt;
    send_table_frame();
    vs_pulse();
    send_table_frame();
    vs_pulse();
    chk("clean_npix", q_rgb.size(), 16);
    if (q_rgb.size() == 16) begin
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < 8; i++) begin
          chk("tbl_rgb", q_rgb[f*8+i], vec[i].rgb);
          chk("tbl_x", q_x[f*8+i], i % H_ACT);
          chk("tbl_y", q_y[f*8+i], i / H_ACT);
          chk("tbl_sof", q_sof[f*8+i], (i == 0));
          chk("tbl_eol", q_eol[f*8+i], ((i % H_ACT) == H_ACT - 1));
        end
      end
    end
    chk("clean_fdone", fd_cnt - fd0, 2);
    chk("clean_count", frame_count, 16'd2);
    chk("clean_err", err_status, 3'b000);

    // Latency: pix_valid two edges after the edge sampling the second byte.
    href = 1'b1; data = 8'h07; tick(1);
    data = 8'hE0; tick(1);
    chk("lat_e0", pif.pix_valid, 1'b0);
    data = 8'h00; tick(1);
    chk("lat_e1", pif.pix_valid, 1'b0);
    data = 8'h1F; tick(1);
    chk("lat_e2_valid", pif.pix_valid, 1'b1);
    chk("lat_e2_rgb", pif.pix_rgb, 24'h00FF00);
    data = 8'h00; tick(1);
    chk("lat_gap", pif.pix_valid, 1'b0);
    data = 8'h00; tick(1);
    chk("lat2_valid", pif.pix_valid, 1'b1);
    chk("lat2_rgb", pif.pix_rgb, 24'h0000FF);
    data = 8'h00; tick(1);
    data = 8'h00; tick(1);
    href = 1'b0; tick(3);
    fill_line(8);
    vs_pulse();
    chk("lat_err", err_status, 3'b000);
    chk("lat_count", frame_count, 16'd3);

    // Odd byte count in a line.
    clear_q();
    fill_line(9);
    chk("odd_npix", q_rgb.size(), 4);
    chk("odd_err", err_status, 3'b001);
    fill_line(8);
    vs_pulse();
    chk("odd_sticky", err_status, 3'b001);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("odd_clr", err_status, 3'b000);

    // Over-long line, then a short frame.
    clear_q();
    fd0 = fd_cnt;
    fill_line(12);
    chk("long_npix", q_rgb.size(), 4);
    if (q_x.size() == 4) chk("long_lastx", q_x[3], 3);
    chk("long_err", err_status, 3'b010);
    vs_pulse();
    chk("short_err", err_status, 3'b110);
    chk("short_fdone", fd_cnt - fd0, 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("short_clr", err_status, 3'b000);

    // Enable dropped mid-frame: frame completes, then idle.
    fill_line(8);
    enable = 1'b0;
    fill_line(8);
    vsync = 1'b1;
    tick(1);
    chk("drop_busy_pre", busy, 1'b1);
    tick(1);
    chk("drop_fdone", frame_done, 1'b1);
    chk("drop_busy_post", busy, 1'b0);
    tick(1);
    vsync = 1'b0;
    tick(3);

    // Enable raised mid-frame: that frame is skipped.
    clear_q();
    fill_line(8);
    enable = 1'b1;
    tick(2);
    fill_line(8);
    chk("raise_skip", q_rgb.size(), 0);
    vs_pulse();
    send_frame(2, 8);
    vs_pulse();
    chk("raise_npix", q_rgb.size(), 8);
    chk("raise_count", frame_count, 16'd7);
    chk("raise_err", err_status, 3'b000);

    // Asynchronous reset in the middle of a line.
    href = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 8'hF8;
      tick(1);
    end
    reset = 1'b1;
    #1;
    chk("arst_valid", pif.pix_valid, 1'b0);
    chk("arst_rgb", pif.pix_rgb, 24'd0);
    chk("arst_xy", {pif.pix_x, pif.pix_y}, 24'd0);
    chk("arst_markers", {pif.sof, pif.eol, frame_done}, 3'b000);
    chk("arst_count", frame_count, 16'd0);
    chk("arst_busy", busy, 1'b0);
    tick(2);
    reset = 1'b0;
    href = 1'b0;
    tick(2);
    clear_q();
    fill_line(8);
    chk("arst_skip", q_rgb.size(), 0);
    vs_pulse();
    send_frame(2, 8);
    vs_pulse();
    chk("arst_npix", q_rgb.size(), 8);
    if (q_rgb.size() == 8) chk("arst_rgb0", q_rgb[0], 24'hFF0000);
    chk("arst_count1", frame_count, 16'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
